updi_rx: RTL and testbench

//  UPDI line receiver: samples the single-wire UPDI data line and deframes UART bytes
//  (1 start, 8 data LSB-first, even parity, 2 stop bits). Good bytes are pushed into the

---
 rtl/updi_rx.sv | 201 ++++++++++++++++++++
 tb/tb_updi_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/updi_rx.sv
// -----------------------------------------------------------------------------
// updi_rx
//   UPDI line receiver. Synchronizes the single-wire UPDI line and deframes
//   UART bytes: 1 start bit, 8 data bits LSB-first, even parity, 2 stop bits.
//   Good bytes are written into the receive FIFO. Bytes with a bad parity or
//   a bad stop bit, and bytes that arrive while the FIFO is full, are dropped
//   and flagged. The receiver ignores the line while rx_enable is low, which
//   is the case whenever the local transmitter drives the shared wire.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UPDI bit (>= 4)
//   CNT_W         bit-timer width, derived from CLKS_PER_BIT
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active high
//   rx_enable       1 = receive, 0 = ignore line and abort the current frame
//   updi_rx_in      raw UPDI line (asynchronous, idle high)
//   out_fifo_data   received byte, valid while out_fifo_wr_en is high
//   out_fifo_full   receive FIFO full
//   out_fifo_wr_en  one-cycle write strobe into the receive FIFO
//   busy            high whenever the receiver is not idle
//   parity_error    one-cycle pulse: parity mismatch, byte dropped
//   frame_error     one-cycle pulse: a stop bit sampled low, byte dropped
//   overflow        one-cycle pulse: good byte while FIFO full, byte dropped
// -----------------------------------------------------------------------------
module updi_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic       updi_rx_in,
  output logic [7:0] out_fifo_data,
  input  logic       out_fifo_full,
  output logic       out_fifo_wr_en,
  output logic       busy,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    PUSH,
    WAIT_IDLE
  } state_t;

  // First sample lands mid-bit: half a bit after the start edge is seen.
  localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] RELOAD_BIT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  state_t           state_next;

  logic             rx_meta;
  logic             rxs;

  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_bit;
  logic             stop1_bit;
  logic             stop2_bit;

  logic             sampling;
  logic             tick;
  logic             start_det;
  logic             frame_bad;
  logic             parity_bad;

  logic             wr_en_d;
  logic             parity_error_d;
  logic             frame_error_d;
  logic             overflow_d;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    sampling   = (state == START)  || (state == DATA)  ||
                 (state == PARITY) || (state == STOP1) || (state == STOP2);
    tick       = sampling && (timer == '0);
    start_det  = (state == IDLE) && rx_enable && !rxs;
    frame_bad  = !stop1_bit || !stop2_bit;
    // Even parity: data bits plus parity bit must hold an even number of ones.
    parity_bad = ^{shreg, par_bit};
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rx_meta        <= 1'b1;
      rxs            <= 1'b1;
      timer          <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      stop1_bit      <= 1'b0;
      stop2_bit      <= 1'b0;
      out_fifo_wr_en <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      rx_meta        <= updi_rx_in;
      rxs            <= rx_meta;
      state          <= state_next;
      out_fifo_wr_en <= wr_en_d;
      parity_error   <= parity_error_d;
      frame_error    <= frame_error_d;
      overflow       <= overflow_d;

      // Bit timer: loaded with half a bit on the start edge, then reloaded
      // with a full bit on every sample so ticks stay CLKS_PER_BIT apart.
      if (!rx_enable) begin
        timer <= '0;
      end else if (start_det) begin
        timer <= HALF_BIT;
      end else if (tick) begin
        timer <= RELOAD_BIT;
      end else if (sampling) begin
        timer <= timer - CNT_W'(1);
      end else begin
        timer <= '0;
      end

      if (rx_enable && tick) begin
        unique case (state)
          START:  bit_idx   <= '0;
          DATA: begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: par_bit   <= rxs;
          STOP1:  stop1_bit <= rxs;
          STOP2:  stop2_bit <= rxs;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (!rx_enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (!rxs) state_next = START;
        START:     if (tick) state_next = rxs ? IDLE : DATA;
        DATA:      if (tick && (bit_idx == 3'd7)) state_next = PARITY;
        PARITY:    if (tick) state_next = STOP1;
        STOP1:     if (tick) state_next = STOP2;
        // Leaving mid-STOP2 lets a start edge right after the stop bit be seen.
        STOP2:     if (tick) state_next = PUSH;
        PUSH:      state_next = frame_bad ? WAIT_IDLE : IDLE;
        // A line held low (break) must not be re-read as a stream of frames.
        WAIT_IDLE: if (rxs) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: PUSH decides, the result is registered one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en_d        = 1'b0;
    parity_error_d = 1'b0;
    frame_error_d  = 1'b0;
    overflow_d     = 1'b0;
    if ((state == PUSH) && rx_enable) begin
      if (frame_bad) begin
        frame_error_d = 1'b1;
      end else if (parity_bad) begin
        parity_error_d = 1'b1;
      end else if (out_fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign out_fifo_data = shreg;

endmodule

// File: tb/tb_updi_rx.sv
module tb_updi_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_enable;
  logic       updi_rx_in;
  logic [7:0] out_fifo_data;
  logic       out_fifo_full;
  logic       out_fifo_wr_en;
  logic       busy;
  logic       parity_error;
  logic       frame_error;
  logic       overflow;

  int total;
  int bad;

  // Pulse monitor counters (written only by the monitor process).
  int         wr_cnt;
  int         perr_cnt;
  int         ferr_cnt;
  int         ovf_cnt;
  int         multi_cnt;
  logic [7:0] data_log [0:63];

  // Snapshots taken by the stimulus process.
  int w0, p0, f0, o0;

  updi_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_enable      (rx_enable),
    .updi_rx_in     (updi_rx_in),
    .out_fifo_data  (out_fifo_data),
    .out_fifo_full  (out_fifo_full),
    .out_fifo_wr_en (out_fifo_wr_en),
    .busy           (busy),
    .parity_error   (parity_error),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_cnt = 0; perr_cnt = 0; ferr_cnt = 0; ovf_cnt = 0; multi_cnt = 0;
  end

  always @(negedge clk) begin
    if (out_fifo_wr_en) begin
      if (wr_cnt < 64) data_log[wr_cnt] = out_fifo_data;
      wr_cnt = wr_cnt + 1;
    end
    if (parity_error) perr_cnt = perr_cnt + 1;
    if (frame_error)  ferr_cnt = ferr_cnt + 1;
    if (overflow)     ovf_cnt  = ovf_cnt + 1;
    if ((int'(out_fifo_wr_en) + int'(parity_error) + int'(frame_error) + int'(overflow)) > 1)
      multi_cnt = multi_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt; p0 = perr_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
  endtask

  task automatic check_deltas(input string tag, input int wr, input int pe, input int fe, input int ov);
    check({tag, "_wr"},   wr_cnt - w0,   wr);
    check({tag, "_perr"}, perr_cnt - p0, pe);
    check({tag, "_ferr"}, ferr_cnt - f0, fe);
    check({tag, "_ovf"},  ovf_cnt - o0,  ov);
  endtask

  // Drive the line at a negedge and hold it for n clocks.
  task automatic line(input logic v, input int n);
    updi_rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
    line(p, CPB);
    line(s1, CPB);
    line(s2, CPB);
    updi_rx_in = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    rx_enable     = 1'b1;
    updi_rx_in    = 1'b1;
    out_fifo_full = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_wr_en",  out_fifo_wr_en, 0);
    check("rst_perr",   parity_error,   0);
    check("rst_ferr",   frame_error,    0);
    check("rst_ovf",    overflow,       0);
    check("rst_busy",   busy,           0);
    check("rst_data",   out_fifo_data,  8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single good byte 0x55 (parity 0)
    snap();
    send_good(8'h55);
    repeat (24) @(negedge clk);
    check_deltas("b55", 1, 0, 0, 0);
    check("b55_data", data_log[w0], 8'h55);
    check("b55_busy", busy, 0);

    // Back-to-back 0x40, 0x13 with no gap
    snap();
    send_good(8'h40);
    send_good(8'h13);
    repeat (24) @(negedge clk);
    check_deltas("b2b", 2, 0, 0, 0);
    check("b2b_data0", data_log[w0],     8'h40);
    check("b2b_data1", data_log[w0 + 1], 8'h13);

    // Parity error on 0x03, then good 0xA5
    snap();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    repeat (24) @(negedge clk);
    check_deltas("par", 0, 1, 0, 0);
    snap();
    send_good(8'hA5);
    repeat (24) @(negedge clk);
    check_deltas("a5", 1, 0, 0, 0);
    check("a5_data", data_log[w0], 8'hA5);

    // STOP1 low, line then held low for 3 frame times
    snap();
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(((8'h22 >> i) & 8'h01) != 0, CPB);
    line(1'b0, CPB);              // parity of 0x22 is 0
    line(1'b0, 3 * 12 * CPB);     // stop bits and beyond held low
    check("brk_busy_low", busy, 1);
    check_deltas("brk", 0, 0, 1, 0);
    updi_rx_in = 1'b1;
    repeat (24) @(negedge clk);
    check("brk_busy_rel", busy, 0);
    check("brk_ferr_once", ferr_cnt - f0, 1);
    snap();
    send_good(8'h7E);
    repeat (24) @(negedge clk);
    check_deltas("b7e", 1, 0, 0, 0);
    check("b7e_data", data_log[w0], 8'h7E);

    // Overflow with FIFO full, then accepted
    snap();
    out_fifo_full = 1'b1;
    send_good(8'h81);
    repeat (24) @(negedge clk);
    check_deltas("ovf", 0, 0, 0, 1);
    out_fifo_full = 1'b0;
    snap();
    send_good(8'h81);
    repeat (24) @(negedge clk);
    check_deltas("b81", 1, 0, 0, 0);
    check("b81_data", data_log[w0], 8'h81);

    // 5-clock low glitch in IDLE: false start
    snap();
    line(1'b0, 5);
    check("glitch_busy_hi", busy, 1);
    line(1'b1, 30);
    check("glitch_busy_lo", busy, 0);
    check_deltas("glitch", 0, 0, 0, 0);

    // rx_enable dropped during DATA bit 4 (byte 0xF0)
    snap();
    line(1'b0, CPB);
    for (int i = 0; i < 4; i++) line(1'b0, CPB);
    line(1'b1, CPB / 2);
    check("en_busy_before", busy, 1);
    rx_enable = 1'b0;
    @(negedge clk);
    check("en_busy_after", busy, 0);
    line(1'b1, 12 * CPB);
    rx_enable = 1'b1;
    repeat (24) @(negedge clk);
    check_deltas("en", 0, 0, 0, 0);

    // rst asserted during PARITY (byte 0xC3)
    snap();
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(((8'hC3 >> i) & 8'h01) != 0, CPB);
    line(1'b0, CPB / 2);
    check("prst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("prst_busy", busy,           0);
    check("prst_data", out_fifo_data,  8'h00);
    check("prst_wr",   out_fifo_wr_en, 0);
    check("prst_flags", {parity_error, frame_error, overflow}, 3'b000);
    updi_rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    check_deltas("prst", 0, 0, 0, 0);
    check("prst_idle", busy, 0);

    check("one_strobe_per_cycle", multi_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
